// File: rtl/iir_output_decimator_if.sv
// Handshake bundle between the IIR output decimator and its neighbours:
// the filter-side sample stream and the consumer-side FIFO drain port.
interface iir_output_decimator_if #(
  parameter int NB_DATA_IN  = 12,
  parameter int NB_DATA_OUT = 8,
  parameter int FIFO_DEPTH  = 4
);
  localparam int NB_LEVEL = $clog2(FIFO_DEPTH + 1);

  logic signed [NB_DATA_IN-1:0]  i_data;
  logic                          i_enable;
  logic                          i_ready;
  logic                          i_clear_overflow;
  logic signed [NB_DATA_OUT-1:0] o_data;
  logic                          o_valid;
  logic [NB_LEVEL-1:0]           o_level;
  logic                          o_overflow;

  // Environment side: drives the sample stream and the consumer ready.
  modport master (
    output i_data, i_enable, i_ready, i_clear_overflow,
    input  o_data, o_valid, o_level, o_overflow
  );

  // Decimator side.
  modport slave (
    input  i_data, i_enable, i_ready, i_clear_overflow,
    output o_data, o_valid, o_level, o_overflow
  );
endinterface

// File: rtl/iir_output_decimator.sv
// Keeps one filter sample in DECIM_FACTOR, scales and saturates it to a narrow
// signed word, and buffers it in a first-word-fall-through FIFO with overflow flag.
module iir_output_decimator #(
  parameter int NB_DATA_IN   = 12,
  parameter int NB_DATA_OUT  = 8,
  parameter int NB_SHIFT     = 2,
  parameter int DECIM_FACTOR = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  iir_output_decimator_if.slave  bus
);

  localparam int NB_PTR   = $clog2(FIFO_DEPTH);
  localparam int NB_LEVEL = $clog2(FIFO_DEPTH + 1);
  localparam int NB_DCNT  = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;

  localparam logic [NB_DCNT-1:0]  DCNT_LAST  = NB_DCNT'(DECIM_FACTOR - 1);
  localparam logic [NB_LEVEL-1:0] LEVEL_FULL = NB_LEVEL'(FIFO_DEPTH);

  // Output range expressed at input width so the comparison sees the full shifted value.
  localparam logic signed [NB_DATA_IN-1:0] SAT_MAX = NB_DATA_IN'((2 ** (NB_DATA_OUT - 1)) - 1);
  localparam logic signed [NB_DATA_IN-1:0] SAT_MIN = ~SAT_MAX;

  logic [NB_DCNT-1:0]            r_dcnt;
  logic signed [NB_DATA_OUT-1:0] r_mem [FIFO_DEPTH];
  logic [NB_PTR-1:0]             r_wr_ptr;
  logic [NB_PTR-1:0]             r_rd_ptr;
  logic [NB_LEVEL-1:0]           r_level;
  logic                          r_overflow;

  logic                          w_push;
  logic                          w_pop;
  logic                          w_write;
  logic                          w_drop;
  logic                          w_full;
  logic                          w_empty;
  logic signed [NB_DATA_IN-1:0]  w_shifted;
  logic signed [NB_DATA_OUT-1:0] w_sat;

  // ---------------------------------------------------------------------------
  // Decimation counter: one push per DECIM_FACTOR enabled cycles, starting at 0
  // so the first enabled cycle after reset produces a sample.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dcnt <= '0;
    end else if (bus.i_enable) begin
      r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + NB_DCNT'(1);
    end
  end

  assign w_push = bus.i_enable && (r_dcnt == '0);

  // ---------------------------------------------------------------------------
  // Scale (floor shift) and saturate to the output word.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_shifted = bus.i_data >>> NB_SHIFT;
    w_sat     = w_shifted[NB_DATA_OUT-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[NB_DATA_OUT-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[NB_DATA_OUT-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. A full FIFO still accepts a word when the head leaves in the
  // same cycle; otherwise the word is dropped and the overflow flag is raised.
  // ---------------------------------------------------------------------------
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LEVEL_FULL);
  assign w_pop   = !w_empty && bus.i_ready;
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // NOTE: the storage array carries no reset; occupancy and pointers define
  // which entries are meaningful, and o_data is masked while empty.
  always_ff @(posedge i_clock) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_sat;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + NB_PTR'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + NB_PTR'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_level <= r_level + NB_LEVEL'(1);
        2'b01:   r_level <= r_level - NB_LEVEL'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs depend on registered state only.
  // ---------------------------------------------------------------------------
  assign bus.o_valid    = !w_empty;
  assign bus.o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.o_level    = r_level;
  assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_iir_output_decimator.sv
// Bench for iir_output_decimator: directed scenarios plus a random stream, all
// compared every cycle against a queue-based model of decimate/scale/FIFO.
module tb_iir_output_decimator;

  localparam int NB_IN   = 12;
  localparam int NB_OUT  = 8;
  localparam int SHIFT   = 2;
  localparam int DECIM   = 4;
  localparam int DEPTH   = 4;
  localparam int OUT_MAX = (2 ** (NB_OUT - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (NB_OUT - 1));

  logic clk;
  logic rst_n;

  iir_output_decimator_if #(
    .NB_DATA_IN (NB_IN),
    .NB_DATA_OUT(NB_OUT),
    .FIFO_DEPTH (DEPTH)
  ) bus ();

  iir_output_decimator #(
    .NB_DATA_IN  (NB_IN),
    .NB_DATA_OUT (NB_OUT),
    .NB_SHIFT    (SHIFT),
    .DECIM_FACTOR(DECIM),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_q[$];
  int m_dcnt = 0;
  bit m_ovf  = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_ref(input int v);
    int s;
    s = v >>> SHIFT;
    if (s > OUT_MAX) return OUT_MAX;
    if (s < OUT_MIN) return OUT_MIN;
    return s;
  endfunction

  // Applies the current inputs to the model, as the DUT will at the next edge.
  task automatic model_step();
    bit pop;
    bit push;
    pop  = (m_q.size() != 0) && bus.i_ready;
    push = bus.i_enable && (m_dcnt == 0);
    if (bus.i_enable) m_dcnt = (m_dcnt + 1) % DECIM;
    if (bus.i_clear_overflow) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(sat_ref(int'(bus.i_data)));
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dcnt = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic compare_all();
    check("valid", int'(bus.o_valid), (m_q.size() != 0) ? 1 : 0);
    check("data", int'(bus.o_data), (m_q.size() != 0) ? m_q[0] : 0);
    check("level", int'(bus.o_level), m_q.size());
    check("overflow", int'(bus.o_overflow), int'(m_ovf));
  endtask

  // One clock: model update, edge, then sample 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Advance with enable high (no push) until the next cycle is a push cycle.
  task automatic align(input bit rdy);
    bus.i_enable         = 1'b1;
    bus.i_ready          = rdy;
    bus.i_clear_overflow = 1'b0;
    for (int i = 0; i < DECIM && m_dcnt != 0; i++) tick();
  endtask

  task automatic push_tick(input int value, input bit rdy, input bit clr);
    align(rdy);
    bus.i_data           = NB_IN'(value);
    bus.i_enable         = 1'b1;
    bus.i_ready          = rdy;
    bus.i_clear_overflow = clr;
    tick();
    bus.i_clear_overflow = 1'b0;
  endtask

  task automatic rest_ticks(input bit rdy);
    bus.i_enable = 1'b1;
    bus.i_ready  = rdy;
    for (int i = 1; i < DECIM; i++) tick();
  endtask

  task automatic idle_ticks(input int n, input bit rdy, input bit clr);
    bus.i_enable         = 1'b0;
    bus.i_ready          = rdy;
    bus.i_clear_overflow = clr;
    for (int i = 0; i < n; i++) tick();
    bus.i_clear_overflow = 1'b0;
  endtask

  int sat_in[5]  = '{2047, -2048, -5, 508, -512};
  int sat_exp[5] = '{127, -128, -2, 127, -128};
  int vcount;

  initial begin
    rst_n                = 1'b0;
    bus.i_data           = '0;
    bus.i_enable         = 1'b0;
    bus.i_ready          = 1'b0;
    bus.i_clear_overflow = 1'b0;
    #1;
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_level", int'(bus.o_level), 0);
    check("rst_overflow", int'(bus.o_overflow), 0);
    check("rst_data", int'(bus.o_data), 0);
    #11 rst_n = 1'b1;

    // Steady stream, data incrementing by 4, consumer always ready.
    bus.i_enable = 1'b1;
    bus.i_ready  = 1'b1;
    for (int k = 0; k < 32; k++) begin
      bus.i_data = NB_IN'(4 * k);
      tick();
      check("steady_level_le1", int'(bus.o_level <= 1), 1);
    end

    // Saturation corners and floor shift.
    for (int i = 0; i < 5; i++) begin
      push_tick(sat_in[i], 1'b1, 1'b0);
      check("sat_word", int'(bus.o_data), sat_exp[i]);
      rest_ticks(1'b1);
    end

    // Fill with consumer stalled; fifth push is dropped.
    for (int i = 0; i < 5; i++) begin
      push_tick(40 * i, 1'b0, 1'b0);
      check("fill_level", int'(bus.o_level), (i < 4) ? i + 1 : 4);
      rest_ticks(1'b0);
    end
    check("fill_overflow", int'(bus.o_overflow), 1);
    bus.i_enable = 1'b0;
    bus.i_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_word", int'(bus.o_data), 10 * i);
      tick();
    end
    check("drain_empty", int'(bus.o_valid), 0);

    // Clear alone drops the flag.
    idle_ticks(1, 1'b0, 1'b1);
    check("clear_alone", int'(bus.o_overflow), 0);

    // Full FIFO, pop and push in the same cycle.
    for (int i = 0; i < 4; i++) begin
      push_tick(4 * (20 + i), 1'b0, 1'b0);
      rest_ticks(1'b0);
    end
    push_tick(4 * 50, 1'b1, 1'b0);
    check("full_pp_level", int'(bus.o_level), 4);
    check("full_pp_overflow", int'(bus.o_overflow), 0);
    rest_ticks(1'b0);
    bus.i_enable = 1'b0;
    bus.i_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pp_order", int'(bus.o_data), (i < 3) ? 21 + i : 50);
      tick();
    end

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < 4; i++) begin
      push_tick(4 * i, 1'b0, 1'b0);
      rest_ticks(1'b0);
    end
    push_tick(4 * 99, 1'b0, 1'b1);
    check("set_wins", int'(bus.o_overflow), 1);
    rest_ticks(1'b0);
    idle_ticks(1, 1'b0, 1'b1);
    check("later_clear", int'(bus.o_overflow), 0);
    idle_ticks(5, 1'b1, 1'b0);

    // Enable toggling: one push per four enabled cycles.
    align(1'b1);
    vcount = 0;
    for (int i = 0; i < 32; i++) begin
      bus.i_enable = (i % 2 == 0);
      bus.i_ready  = 1'b1;
      bus.i_data   = NB_IN'($urandom);
      tick();
      if (bus.o_valid) vcount++;
    end
    check("gap_pushes", vcount, 4);

    // Random stream; ready probability varies per block to reach full/overflow.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 500; i++) begin
        bus.i_enable         = ($urandom_range(0, 3) != 0);
        bus.i_ready          = ($urandom_range(0, 5) < blk);
        bus.i_clear_overflow = ($urandom_range(0, 15) == 0);
        bus.i_data           = NB_IN'($urandom);
        tick();
      end
    end
    bus.i_clear_overflow = 1'b0;
    idle_ticks(6, 1'b1, 1'b1);

    // Mid-stream asynchronous reset with three words buffered and overflow set.
    for (int i = 0; i < 5; i++) begin
      push_tick(8 * i, 1'b0, 1'b0);
      rest_ticks(1'b0);
    end
    idle_ticks(1, 1'b1, 1'b0);
    check("pre_rst_level", int'(bus.o_level), 3);
    check("pre_rst_overflow", int'(bus.o_overflow), 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_valid", int'(bus.o_valid), 0);
    check("async_rst_level", int'(bus.o_level), 0);
    check("async_rst_overflow", int'(bus.o_overflow), 0);
    model_reset();
    #2 rst_n = 1'b1;

    // First enabled cycle after reset pushes.
    bus.i_enable = 1'b1;
    bus.i_ready  = 1'b0;
    bus.i_data   = NB_IN'(4 * 7);
    tick();
    check("post_rst_first", int'(bus.o_data), 7);
    rest_ticks(1'b1);
    idle_ticks(2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_output_decimator.md
# iir_output_decimator

Downstream stage of the IIR filter. Takes the filter's full-width output every clock, keeps one sample in every DECIM_FACTOR, scales and saturates it to a narrow signed word, and buffers the results in a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready handshake. Lost samples are reported on a sticky overflow flag.

## Interface
- NB_DATA_IN, 12: width of i_data. Equal to the filter's output width.
- NB_DATA_OUT, 8: width of o_data. Signed.
- NB_SHIFT, 2: arithmetic right shift applied before saturation. Valid range 0..NB_DATA_IN-1.
- DECIM_FACTOR, 4: decimation ratio. Must be ≥1; 1 means no decimation.
- FIFO_DEPTH, 4: number of FIFO entries. Power of two, ≥2.
- i_clock  input  1  single clock; all logic is rising-edge.
- i_reset_n  input  1  reset; asynchronous assertion, active-low.
- i_data  input  NB_DATA_IN  signed filter output, sampled every enabled cycle.
- i_enable  input  1  input qualifier; the decimation counter advances only when it is 1.
- i_ready  input  1  consumer ready.
- i_clear_overflow  input  1  synchronous clear of o_overflow.
- o_data  output  NB_DATA_OUT  FIFO head word; '0 when o_valid=0.
- o_valid  output  1  FIFO not empty.
- o_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy, 0..FIFO_DEPTH.
- o_overflow  output  1  sticky: set when a decimated sample was dropped.

## Operation
- Decimation counter `dcnt`, range 0..DECIM_FACTOR-1.
  - It increments on each cycle with i_enable=1 and wraps to 0 after DECIM_FACTOR-1.
  - With i_enable=0 it holds its value.
- Push strobe: i_enable=1 and dcnt==0. The first enabled cycle after reset therefore produces a push.
- Scaling: s = i_data >>> NB_SHIFT, an arithmetic shift that floors toward negative infinity.
- Saturation to the NB_DATA_OUT signed range (-128..127 at defaults):
  - s > 127 → 127.
  - s < -128 → -128.
  - Otherwise s is truncated to NB_DATA_OUT bits.
- FIFO: a register array with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus an occupancy counter.
- Pop occurs when o_valid=1 and i_ready=1.
- Push rules:
  - Not full: the word is written.
  - Full, and a pop happens in the same cycle: the word is written and the level is unchanged.
  - Full, and no pop: the word is dropped, pointers are unchanged, and o_overflow is set.
- Same-cycle push and pop when not full and not empty: both happen and the level is unchanged.
- Empty FIFO: there is no bypass. A pushed word becomes visible only on the following cycle.
- o_overflow:
  - Set by a drop and held until cleared by i_clear_overflow=1.
  - If a drop and the clear occur in the same cycle, the flag ends at 1 (set wins).
- i_ready is ignored while o_valid=0.

## Timing
- Reset (i_reset_n=0) asynchronously forces: dcnt=0, both pointers 0, level 0, o_valid=0, o_data=0, o_overflow=0.
  - Reset release is synchronous to i_clock.
  - A reset asserted mid-stream discards all buffered words.
- Latency: a push strobe at rising edge k gives o_valid=1 and o_data=sat(word) after edge k, so the word is visible in cycle k+1.
- Pop at edge k: the next entry, or o_valid=0, appears after edge k.
- o_level updates on the same edge as the push or pop that changes it.
- All outputs are registered or derived from registered state only. There is no combinational path from i_data or i_ready to any output.
- Steady-state output rate is 1 word per DECIM_FACTOR enabled cycles. With i_ready held at 1 the FIFO never exceeds level 1.

## Test plan
- Reset then steady stream: i_enable=1, i_ready=1, i_data=0,4,8,… incrementing by 4 each cycle.
  - o_data shows 0,4,8,… (i_data[4k]>>>2), one valid cycle per group of 4 cycles.
  - o_level never exceeds 1.
- Saturation: i_data=2047 → o_data=127. i_data=-2048 → o_data=-128. i_data=-5 → o_data=-2 (floor shift). i_data=508 → o_data=127.
- Fill and overflow: i_ready=0 for 5 decimated pushes.
  - o_level steps 1,2,3,4,4.
  - o_overflow rises after the 5th push.
  - Then i_ready=1: exactly the first 4 words drain in order.
- Full plus simultaneous pop and push: with level=4, i_ready=1 on a push cycle.
  - Level stays 4, no overflow, and the new word comes out last.
- Overflow clear priority: assert i_clear_overflow in the same cycle as a drop → o_overflow stays 1. Clear alone on a later cycle → 0.
- i_enable gaps and mid-stream reset:
  - With i_enable toggling 1,0,1,0, a push happens every 4th enabled cycle only.
  - Pulse i_reset_n low with level=3: o_valid, o_level, and o_overflow go to 0 immediately, with no clock edge required.
